// File: rtl/regfile_wb_arbiter_if.sv
// Register-file write-back bus: two requesters (A = pipeline write-back,
// B = multi-cycle unit) and the shared register-file write port they feed.
interface regfile_wb_arbiter_if;
  logic        a_valid;
  logic        a_ready;
  logic [4:0]  a_reg;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_reg;
  logic [31:0] b_data;
  logic        regwrite;
  logic [4:0]  writereg;
  logic [31:0] writedata;
  logic [3:0]  b_wait_cnt;

  // Requester side: drives both write requests, observes grants and the write port.
  modport master (
    output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    input  a_ready, b_ready, regwrite, writereg, writedata, b_wait_cnt
  );

  // Arbiter side.
  modport slave (
    input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    output a_ready, b_ready, regwrite, writereg, writedata, b_wait_cnt
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between writer A (fixed
// priority) and writer B. After STARVE_LIMIT consecutive B denials the next
// cycle is reserved for B. The accepted request is registered, so the write
// port is driven one cycle after the handshake. Register 0 is never written.
module regfile_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4  // legal range 1..15
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_NORMAL  = 1'b0,
    ST_FORCE_B = 1'b1
  } state_e;

  // Denial count at which the current collision becomes the last one allowed.
  localparam logic [3:0] LIMIT_M1 = 4'(STARVE_LIMIT - 32'd1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        regwrite_q, regwrite_d;
  logic [4:0]  writereg_q, writereg_d;
  logic [31:0] writedata_q, writedata_d;

  logic        a_ready_s;
  logic        b_ready_s;
  logic        a_xfer_s;
  logic        b_xfer_s;

  // Grant signals: combinational from state and valids, held low during reset.
  always_comb begin
    a_ready_s = 1'b0;
    b_ready_s = 1'b0;
    if (reset) begin
      a_ready_s = 1'b0;
      b_ready_s = 1'b0;
    end else begin
      case (state_q)
        ST_NORMAL: begin
          a_ready_s = 1'b1;
          b_ready_s = !bus.a_valid;
        end
        ST_FORCE_B: begin
          a_ready_s = 1'b0;
          b_ready_s = 1'b1;
        end
        default: begin
          a_ready_s = 1'b0;
          b_ready_s = 1'b0;
        end
      endcase
    end
  end

  assign a_xfer_s = bus.a_valid & a_ready_s;
  assign b_xfer_s = bus.b_valid & b_ready_s;

  // Next state and starvation counter; the counter saturates at LIMIT-1 on the forcing denial.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_NORMAL: begin
        if (!bus.b_valid) begin
          cnt_d = 4'd0;
        end else if (b_xfer_s) begin
          cnt_d = 4'd0;
        end else if (bus.a_valid) begin
          if (cnt_q == LIMIT_M1) begin
            state_d = ST_FORCE_B;
            cnt_d   = cnt_q;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_FORCE_B: begin
        state_d = ST_NORMAL;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = ST_NORMAL;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Write-port stage: load the winner; a write to register 0 loads but never enables.
  always_comb begin
    regwrite_d  = 1'b0;
    writereg_d  = writereg_q;
    writedata_d = writedata_q;
    if (a_xfer_s) begin
      regwrite_d  = (bus.a_reg != 5'd0);
      writereg_d  = bus.a_reg;
      writedata_d = bus.a_data;
    end else if (b_xfer_s) begin
      regwrite_d  = (bus.b_reg != 5'd0);
      writereg_d  = bus.b_reg;
      writedata_d = bus.b_data;
    end else begin
      regwrite_d  = 1'b0;
      writereg_d  = writereg_q;
      writedata_d = writedata_q;
    end
  end

  // State, counter and write-port registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_NORMAL;
      cnt_q       <= 4'd0;
      regwrite_q  <= 1'b0;
      writereg_q  <= 5'd0;
      writedata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      regwrite_q  <= regwrite_d;
      writereg_q  <= writereg_d;
      writedata_q <= writedata_d;
    end
  end

  assign bus.a_ready    = a_ready_s;
  assign bus.b_ready    = b_ready_s;
  assign bus.regwrite   = regwrite_q;
  assign bus.writereg   = writereg_q;
  assign bus.writedata  = writedata_q;
  assign bus.b_wait_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter. Stimulus pushes expected register
// writes (with the cycle they must appear in) into a queue; a monitor on the
// falling edge pops and compares, and demands regwrite=0 in every other cycle.
module tb_regfile_wb_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  typedef struct {
    int          due;
    logic [4:0]  r;
    logic [31:0] d;
  } exp_t;

  exp_t exp_q[$];

  regfile_wb_arbiter_if if0();
  regfile_wb_arbiter_if if1();

  regfile_wb_arbiter #(.STARVE_LIMIT(4)) u_dut0 (.clk(clk), .reset(reset), .bus(if0));
  regfile_wb_arbiter #(.STARVE_LIMIT(1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: expected writes must appear exactly in their due cycle, nothing else.
  exp_t e;
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      chk("regwrite", 32'(if0.regwrite), 32'd1);
      chk("writereg", 32'(if0.writereg), 32'(e.r));
      chk("writedata", if0.writedata, e.d);
    end else begin
      chk("idle_regwrite", 32'(if0.regwrite), 32'd0);
    end
  end

  // One cycle of stimulus on DUT0: drive after the falling edge, check grants and
  // counter, and queue the write that the hand-computed grant implies.
  task automatic step(input logic rst, input logic av, input logic [4:0] ar, input logic [31:0] ad,
                      input logic bv, input logic [4:0] br, input logic [31:0] bd,
                      input logic ear, input logic ebr, input logic [3:0] ecnt);
    exp_t n;
    @(negedge clk);
    reset       = rst;
    if0.a_valid = av;
    if0.a_reg   = ar;
    if0.a_data  = ad;
    if0.b_valid = bv;
    if0.b_reg   = br;
    if0.b_data  = bd;
    #1;
    chk("a_ready", 32'(if0.a_ready), 32'(ear));
    chk("b_ready", 32'(if0.b_ready), 32'(ebr));
    chk("b_wait_cnt", 32'(if0.b_wait_cnt), 32'(ecnt));
    n.due = cyc + 1;
    if (ear && av && ar != 5'd0) begin
      n.r = ar; n.d = ad; exp_q.push_back(n);
    end else if (ebr && bv && br != 5'd0) begin
      n.r = br; n.d = bd; exp_q.push_back(n);
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 4'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    if0.a_valid = 1'b0; if0.a_reg = 5'd0; if0.a_data = 32'd0;
    if0.b_valid = 1'b0; if0.b_reg = 5'd0; if0.b_data = 32'd0;
    if1.a_valid = 1'b0; if1.a_reg = 5'd0; if1.a_data = 32'd0;
    if1.b_valid = 1'b0; if1.b_reg = 5'd0; if1.b_data = 32'd0;

    // reset held: grants forced low
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 4'd0);
    step(1'b1, 1'b1, 5'd2, 32'd7, 1'b1, 5'd3, 32'd8, 1'b0, 1'b0, 4'd0);

    // A only: r3 <= DEADBEEF
    step(1'b0, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 4'd0);
    idle();

    // reset mid-stream: write r4 first, then a_valid to r5 together with reset
    step(1'b0, 1'b1, 5'd4, 32'hA5A5A5A5, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b1, 5'd5, 32'h55555555, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 4'd0);
    idle();
    chk("rst_writereg", 32'(if0.writereg), 32'd0);
    chk("rst_writedata", if0.writedata, 32'd0);

    // B only: r7 <= 12345678
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h12345678, 1'b1, 1'b1, 4'd0);
    idle();

    // zero register: accepted, no write enable, port still loads
    step(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 4'd0);
    idle();
    chk("zero_writereg", 32'(if0.writereg), 32'd0);
    chk("zero_writedata", if0.writedata, 32'hFFFFFFFF);

    // same register: A r9=1 then B r9=2, back-to-back
    step(1'b0, 1'b1, 5'd9, 32'd1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'd2, 1'b1, 1'b1, 4'd0);
    idle();

    // counter cleared when b_valid drops, then B wins once A goes idle
    step(1'b0, 1'b1, 5'd20, 32'd100, 1'b1, 5'd21, 32'd200, 1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b1, 5'd20, 32'd101, 1'b1, 5'd21, 32'd200, 1'b1, 1'b0, 4'd1);
    step(1'b0, 1'b1, 5'd20, 32'd102, 1'b0, 5'd21, 32'd200, 1'b1, 1'b0, 4'd2);
    step(1'b0, 1'b1, 5'd20, 32'd103, 1'b1, 5'd21, 32'd200, 1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd21, 32'd200, 1'b1, 1'b1, 4'd1);
    idle();

    // starvation with limit 4: A wins 4 times, B forced, A resumes
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 5'd10, 32'(i), 1'b1, 5'd11, 32'hB0B0B0B0, 1'b1, 1'b0, 4'(i));
    step(1'b0, 1'b1, 5'd10, 32'd4, 1'b1, 5'd11, 32'hB0B0B0B0, 1'b0, 1'b1, 4'd3);
    step(1'b0, 1'b1, 5'd10, 32'd4, 1'b1, 5'd12, 32'hC0C0C0C0, 1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC0C0C0C0, 1'b1, 1'b1, 4'd1);
    idle();

    // limit 1 instance: every collision alternates A, B, A, B
    @(negedge clk);
    if1.a_valid = 1'b1; if1.a_reg = 5'd13; if1.a_data = 32'h13;
    if1.b_valid = 1'b1; if1.b_reg = 5'd14; if1.b_data = 32'h14;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk("lim1_a_ready", 32'(if1.a_ready), 32'(i % 2 == 0));
      chk("lim1_b_ready", 32'(if1.b_ready), 32'(i % 2 == 1));
    end
    @(negedge clk);
    if1.a_valid = 1'b0;
    if1.b_valid = 1'b0;
    #1;
    chk("lim1_regwrite", 32'(if1.regwrite), 32'd1);
    chk("lim1_writereg", 32'(if1.writereg), 32'd14);

    // drain: every queued write must have been seen
    repeat (3) @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
